dram_port_arbiter: RTL and testbench
====================================

// Module: dram_port_arbiter
// PURPOSE
//  Shares the single-port data RAM (memory-mapped IO included) between the CPU data port and a
//  second master (DMA/debug loader). Accepts valid/ready commands from both requesters and issues
//  at most one registered command per cycle to the RAM. Routes synchronous read data back to the
//  owning requester and bounds CPU starvation of the DMA port. Sits between cpu/DMA and lab5dram.
// PARAMETERS
//  AW         8  address width (RAM ADDR)
//  DW         8  data width (RAM DATA/Q)
//  RD_LAT     1  cycles from MEM_ADDR presented to MEM_Q valid (>=1)
//  MAX_BURST  4  consecutive CPU grants allowed while DMA_REQ high before DMA gets one slot (>=1)
// PORTS
//  CLK        in   1   system clock (var_clk output), rising edge
//  RESET      in   1   asynchronous, active-high reset
//  CPU_REQ    in   1   CPU command valid; held with fields stable until CPU_GNT
//  CPU_WE     in   1   1 = write, 0 = read
//  CPU_ADDR   in   AW  CPU address
//  CPU_WDATA  in   DW  CPU write data
//  CPU_GNT    out  1   command accepted this cycle (transfer on edge where REQ&GNT)
//  CPU_VALID  out  1   one-cycle pulse: CPU_RDATA holds read result
//  CPU_RDATA  out  DW  CPU read data
//  DMA_REQ/DMA_WE/DMA_ADDR/DMA_WDATA/DMA_GNT/DMA_VALID/DMA_RDATA: same as CPU_* for DMA port
//  MEM_ADDR   out  AW  registered RAM address
//  MEM_DATA   out  DW  registered RAM write data
//  MEM_MW     out  1   registered RAM write enable, one cycle per accepted write
//  MEM_Q      in   DW  RAM read data
// BEHAVIOUR
//  - Reset (async): MEM_ADDR/MEM_DATA/MEM_MW=0, all GNT/VALID/RDATA=0, burst cnt=0, tag pipe
//    cleared. Reset mid-read discards the in-flight read; no VALID ever appears for it.
//  - GNT is combinational from REQs + registered arb state; at most one GNT high per cycle.
//  - Accepted command (edge t): MEM_ADDR/DATA/MW reflect it during cycle t+1; MEM_MW=0 otherwise;
//    MEM_ADDR/DATA hold last value when idle. Back-to-back commands every cycle supported.
//  - Read accepted at t: tag {vld,id} enters RD_LAT-deep pipe; at edge t+1+RD_LAT MEM_Q is
//    registered into <id>_RDATA and <id>_VALID pulses for exactly one cycle. Writes: no VALID.
//    Returns are strictly in issue order; RDATA holds last value between pulses.
//  - Arbitration (default): CPU fixed priority. Burst cnt increments on each CPU grant while
//    DMA_REQ high; when cnt==MAX_BURST and DMA_REQ high, DMA granted, cnt cleared. Cnt clears on
//    any DMA grant or any cycle with DMA_REQ low. Only one requester -> it wins every cycle.
//  - No REQ -> no GNT, state unchanged. Requester dropping REQ before GNT: legal, nothing issued.
//  - Address decode/IO mapping is the RAM's concern; arbiter is transparent to it.
// CONFIGURATION
//  DRAM_ARB_RR_EN defined: round-robin; when both REQ, grant the port not granted last
//    (last-grant reg resets to DMA, so CPU wins first tie); burst counter not built, MAX_BURST
//    ignored. Undefined: fixed-priority + MAX_BURST starvation bound as above.
// STRUCTURE
//  - Package dram_arb_pkg: requester id enum (ARB_CPU=0, ARB_DMA=1), read-tag struct {vld,id}.
//  - Sub-module dram_arb_tagpipe: RD_LAT-deep shift register of tags, async-reset to invalid.
//  - Top: grant logic, burst counter/last-grant reg, MEM_* output regs, RDATA/VALID return regs.
// TESTING
//  1. CPU read 0x10 only, RAM returns 0x5A -> CPU_GNT at t, MEM_ADDR=0x10 at t+1, CPU_VALID
//     with CPU_RDATA=0x5A at t+1+RD_LAT; DMA_VALID never.
//  2. DMA write 0x80<-0x3C -> MEM_MW=1 for exactly one cycle with MEM_ADDR=0x80, MEM_DATA=0x3C;
//     no DMA_VALID.
//  3. Both REQ held, MAX_BURST=4 -> grant sequence CPU,CPU,CPU,CPU,DMA,CPU,CPU,CPU,CPU,DMA.
//  4. Alternating reads CPU@0x01, DMA@0x02, CPU@0x03 (RAM data 0xA1/0xA2/0xA3) -> VALIDs in
//     order, each to the correct port with matching data.
//  5. RESET pulsed the cycle after a read is accepted -> all outputs 0, no VALID afterwards.
//  6. DRAM_ARB_RR_EN defined, both REQ held -> grants CPU,DMA,CPU,DMA.

Source files
------------

// File: rtl/dram_arb_pkg.sv
// Shared types for the data-RAM port arbiter: requester ids and the read-return tag.
package dram_arb_pkg;

   typedef enum logic {
      ARB_CPU = 1'b0,
      ARB_DMA = 1'b1
   } arb_id_e;

   typedef struct packed {
      logic    vld;
      arb_id_e id;
   } rd_tag_t;

   localparam rd_tag_t TAG_NONE = '{vld: 1'b0, id: ARB_CPU};

endpackage

// File: rtl/dram_arb_tagpipe.sv
// RD_LAT-deep shift register carrying read tags alongside the RAM's read latency.
module dram_arb_tagpipe
   import dram_arb_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic    clk,
   input  logic    rst,
   input  rd_tag_t tag_in,
   output rd_tag_t tag_out
);

   rd_tag_t stage [RD_LAT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) stage[i] <= TAG_NONE;
      end else begin
         stage[0] <= tag_in;
         for (int i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
      end
   end

   assign tag_out = stage[RD_LAT-1];

endmodule

// File: rtl/dram_port_arbiter.sv
// CPU/DMA arbiter for the single-port data RAM with in-order read return.
// Define DRAM_ARB_RR_EN for round-robin arbitration; default is CPU priority with MAX_BURST bound.
module dram_port_arbiter
   import dram_arb_pkg::*;
#(
   parameter int AW        = 8,
   parameter int DW        = 8,
   parameter int RD_LAT    = 1,
   parameter int MAX_BURST = 4
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          CPU_REQ,
   input  logic          CPU_WE,
   input  logic [AW-1:0] CPU_ADDR,
   input  logic [DW-1:0] CPU_WDATA,
   output logic          CPU_GNT,
   output logic          CPU_VALID,
   output logic [DW-1:0] CPU_RDATA,
   input  logic          DMA_REQ,
   input  logic          DMA_WE,
   input  logic [AW-1:0] DMA_ADDR,
   input  logic [DW-1:0] DMA_WDATA,
   output logic          DMA_GNT,
   output logic          DMA_VALID,
   output logic [DW-1:0] DMA_RDATA,
   output logic [AW-1:0] MEM_ADDR,
   output logic [DW-1:0] MEM_DATA,
   output logic          MEM_MW,
   input  logic [DW-1:0] MEM_Q
);

`ifdef DRAM_ARB_RR_EN
   arb_id_e last_gnt;

   // On a tie the port that did not win last time goes first.
   always_comb begin
      CPU_GNT = CPU_REQ && (!DMA_REQ || last_gnt == ARB_DMA);
      DMA_GNT = DMA_REQ && !CPU_GNT;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)        last_gnt <= ARB_DMA;
      else if (CPU_GNT) last_gnt <= ARB_CPU;
      else if (DMA_GNT) last_gnt <= ARB_DMA;
   end
`else
   localparam int CW = $clog2(MAX_BURST + 1);

   logic [CW-1:0] burst_cnt;
   logic          dma_turn;

   // DMA wins when alone, or once the CPU has used up its burst while DMA waited.
   always_comb begin
      dma_turn = DMA_REQ && (!CPU_REQ || burst_cnt == CW'(MAX_BURST));
      DMA_GNT  = dma_turn;
      CPU_GNT  = CPU_REQ && !dma_turn;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)                   burst_cnt <= '0;
      else if (!DMA_REQ || DMA_GNT) burst_cnt <= '0;
      else if (CPU_GNT)            burst_cnt <= burst_cnt + CW'(1);
   end
`endif

   logic          issue;
   arb_id_e       sel_id;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;
   rd_tag_t       issue_tag;
   rd_tag_t       ret_tag;

   always_comb begin
      issue     = CPU_GNT || DMA_GNT;
      sel_id    = DMA_GNT ? ARB_DMA : ARB_CPU;
      sel_we    = DMA_GNT ? DMA_WE : CPU_WE;
      sel_addr  = DMA_GNT ? DMA_ADDR : CPU_ADDR;
      sel_wdata = DMA_GNT ? DMA_WDATA : CPU_WDATA;
   end

   // Command register: the tag travels with MEM_ADDR so the pipe only covers RAM latency.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         MEM_ADDR  <= '0;
         MEM_DATA  <= '0;
         MEM_MW    <= 1'b0;
         issue_tag <= TAG_NONE;
      end else begin
         MEM_MW    <= issue && sel_we;
         issue_tag <= '{vld: issue && !sel_we, id: sel_id};
         if (issue) begin
            MEM_ADDR <= sel_addr;
            MEM_DATA <= sel_wdata;
         end
      end
   end

   dram_arb_tagpipe #(
      .RD_LAT (RD_LAT)
   ) u_tagpipe (
      .clk     (CLK),
      .rst     (RESET),
      .tag_in  (issue_tag),
      .tag_out (ret_tag)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         CPU_VALID <= 1'b0;
         DMA_VALID <= 1'b0;
         CPU_RDATA <= '0;
         DMA_RDATA <= '0;
      end else begin
         CPU_VALID <= ret_tag.vld && ret_tag.id == ARB_CPU;
         DMA_VALID <= ret_tag.vld && ret_tag.id == ARB_DMA;
         if (ret_tag.vld && ret_tag.id == ARB_CPU) CPU_RDATA <= MEM_Q;
         if (ret_tag.vld && ret_tag.id == ARB_DMA) DMA_RDATA <= MEM_Q;
      end
   end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Scoreboard bench for dram_port_arbiter with a behavioural RAM and arbitration reference model.
module tb_dram_port_arbiter;

   localparam int AW        = 8;
   localparam int DW        = 8;
   localparam int RD_LAT    = 1;
   localparam int MAX_BURST = 4;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          CPU_REQ, CPU_WE, CPU_GNT, CPU_VALID;
   logic [AW-1:0] CPU_ADDR;
   logic [DW-1:0] CPU_WDATA, CPU_RDATA;
   logic          DMA_REQ, DMA_WE, DMA_GNT, DMA_VALID;
   logic [AW-1:0] DMA_ADDR;
   logic [DW-1:0] DMA_WDATA, DMA_RDATA;
   logic [AW-1:0] MEM_ADDR;
   logic [DW-1:0] MEM_DATA, MEM_Q;
   logic          MEM_MW;

   dram_port_arbiter #(
      .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
   ) dut (
      .CLK(CLK), .RESET(RESET),
      .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
      .CPU_GNT(CPU_GNT), .CPU_VALID(CPU_VALID), .CPU_RDATA(CPU_RDATA),
      .DMA_REQ(DMA_REQ), .DMA_WE(DMA_WE), .DMA_ADDR(DMA_ADDR), .DMA_WDATA(DMA_WDATA),
      .DMA_GNT(DMA_GNT), .DMA_VALID(DMA_VALID), .DMA_RDATA(DMA_RDATA),
      .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_MW(MEM_MW), .MEM_Q(MEM_Q)
   );

   // ---------------- clock ----------------
   always #5 CLK = ~CLK;

   // ---------------- synchronous RAM model ----------------
   logic [DW-1:0] ram [256];
   logic [DW-1:0] q_pipe [RD_LAT];

   always @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < 256; i++) ram[i] <= '0;
         for (int i = 0; i < RD_LAT; i++) q_pipe[i] <= '0;
      end else begin
         if (MEM_MW) ram[MEM_ADDR] <= MEM_DATA;
         q_pipe[0] <= ram[MEM_ADDR];
         for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
      end
   end
   assign MEM_Q = q_pipe[RD_LAT-1];

   // ---------------- scoreboard state ----------------
   typedef struct packed {
      logic          id;     // 0 = CPU, 1 = DMA
      logic [DW-1:0] data;
      logic [31:0]   cyc;
   } exp_t;

   exp_t          exp_q[$];
   logic [8:0]    ret_log[$];
   logic [DW-1:0] ref_mem [256];
   int            checks = 0;
   int            failures = 0;
   int            cpu_vcnt = 0;
   int            dma_vcnt = 0;
   logic [31:0]   cyc = 0;
   logic          prev_acc = 1'b0;
   logic          prev_we = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic [DW-1:0] prev_data = '0;
   int            cpu_run = 0;       // CPU grants since DMA started waiting
   logic          last_dma = 1'b1;   // last grant went to DMA

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: actual=0x%0h expected=0x%0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // ---------------- monitor / reference model ----------------
   always @(negedge CLK) begin
      logic exp_cpu, exp_dma;
      logic [AW-1:0] a;
      cyc++;
      if (RESET) begin
         check("rst_mem_bus", {MEM_ADDR, MEM_DATA, MEM_MW}, '0);
         check("rst_ports", {CPU_GNT, DMA_GNT, CPU_VALID, DMA_VALID, CPU_RDATA, DMA_RDATA}, '0);
         exp_q.delete();
         for (int i = 0; i < 256; i++) ref_mem[i] = '0;
         prev_acc = 1'b0;
         cpu_run  = 0;
         last_dma = 1'b1;
      end else begin
         check("mem_mw", MEM_MW, prev_acc && prev_we);
         if (prev_acc) check("mem_addr", MEM_ADDR, prev_addr);
         if (prev_acc && prev_we) check("mem_data", MEM_DATA, prev_data);

         if (CPU_VALID && DMA_VALID) check("one_valid", 2'b11, 2'b01);
         if (CPU_VALID || DMA_VALID) begin
            if (DMA_VALID) dma_vcnt++; else cpu_vcnt++;
            ret_log.push_back({DMA_VALID, DMA_VALID ? DMA_RDATA : CPU_RDATA});
            if (exp_q.size() == 0) begin
               check("unexpected_valid", {CPU_VALID, DMA_VALID}, 2'b00);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("ret_port", DMA_VALID, e.id);
               check("ret_data", DMA_VALID ? DMA_RDATA : CPU_RDATA, e.data);
               check("ret_latency", cyc, e.cyc);
            end
         end

`ifdef DRAM_ARB_RR_EN
         exp_cpu = CPU_REQ && (!DMA_REQ || last_dma);
         exp_dma = DMA_REQ && !exp_cpu;
         if (exp_cpu) last_dma = 1'b0;
         else if (exp_dma) last_dma = 1'b1;
`else
         exp_dma = DMA_REQ && (!CPU_REQ || cpu_run >= MAX_BURST);
         exp_cpu = CPU_REQ && !exp_dma;
         if (!DMA_REQ || exp_dma) cpu_run = 0;
         else if (exp_cpu) cpu_run++;
`endif
         check("grant", {CPU_GNT, DMA_GNT}, {exp_cpu, exp_dma});

         prev_acc = 1'b0;
         if ((CPU_REQ && CPU_GNT) || (DMA_REQ && DMA_GNT)) begin
            prev_acc  = 1'b1;
            prev_we   = DMA_GNT ? DMA_WE : CPU_WE;
            prev_addr = DMA_GNT ? DMA_ADDR : CPU_ADDR;
            prev_data = DMA_GNT ? DMA_WDATA : CPU_WDATA;
            a = prev_addr;
            if (prev_we) ref_mem[a] = prev_data;
            else exp_q.push_back('{id: DMA_GNT, data: ref_mem[a], cyc: cyc + 2 + RD_LAT});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic issue(input logic port, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
      logic done;
      done = 1'b0;
      if (port) begin DMA_REQ = 1'b1; DMA_WE = we; DMA_ADDR = a; DMA_WDATA = d; end
      else      begin CPU_REQ = 1'b1; CPU_WE = we; CPU_ADDR = a; CPU_WDATA = d; end
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge CLK);
         done = port ? DMA_GNT : CPU_GNT;
         tick();
      end
      if (!done) check("issue_timeout", 1'b0, 1'b1);
      if (port) DMA_REQ = 1'b0; else CPU_REQ = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [1:0] glog[$];
      logic [1:0] exp_seq [10];
      logic [1:0] g;
      logic       ca, da;
      int         n, mw_cnt, v_cpu, v_dma;

      RESET = 1'b1;
      CPU_REQ = 0; CPU_WE = 0; CPU_ADDR = '0; CPU_WDATA = '0;
      DMA_REQ = 0; DMA_WE = 0; DMA_ADDR = '0; DMA_WDATA = '0;
      repeat (3) tick();
      RESET = 1'b0;
      tick();

      // Both requesters held: grant order straight out of reset
`ifdef DRAM_ARB_RR_EN
      exp_seq = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
`else
      exp_seq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
`endif
      CPU_REQ = 1; CPU_WE = 0; CPU_ADDR = AW'($urandom);
      DMA_REQ = 1; DMA_WE = 0; DMA_ADDR = AW'($urandom);
      for (int i = 0; i < 60 && glog.size() < 10; i++) begin
         @(negedge CLK);
         g = {CPU_GNT, DMA_GNT};
         if (g != 2'b00) glog.push_back(g);
         tick();
         if (g[1]) CPU_ADDR = AW'($urandom);
         if (g[0]) DMA_ADDR = AW'($urandom);
      end
      CPU_REQ = 0; DMA_REQ = 0;
      check("burst_len", glog.size(), 10);
      for (int i = 0; i < glog.size() && i < 10; i++) check("burst_seq", glog[i], exp_seq[i]);
      repeat (6) tick();

      // Preload RAM through the DMA port
      issue(1'b1, 1'b1, 8'h10, 8'h5A);
      issue(1'b1, 1'b1, 8'h01, 8'hA1);
      issue(1'b1, 1'b1, 8'h02, 8'hA2);
      issue(1'b1, 1'b1, 8'h03, 8'hA3);
      repeat (2) tick();

      // DMA write: exactly one MEM_MW cycle, no return
      v_dma = dma_vcnt;
      issue(1'b1, 1'b1, 8'h80, 8'h3C);
      mw_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         if (MEM_MW) begin
            mw_cnt++;
            check("dma_wr_addr", MEM_ADDR, 8'h80);
            check("dma_wr_data", MEM_DATA, 8'h3C);
         end
         tick();
      end
      check("dma_wr_mw_cycles", mw_cnt, 1);
      check("dma_wr_no_valid", dma_vcnt, v_dma);

      // CPU read of 0x10 with latency check
      v_dma = dma_vcnt;
      issue(1'b0, 1'b0, 8'h10, 8'h00);
      @(negedge CLK);
      check("cpu_rd_mem_addr", MEM_ADDR, 8'h10);
      n = 1;
      while (!CPU_VALID && n < 10) begin
         @(negedge CLK);
         n++;
      end
      check("cpu_rd_latency", n, 2 + RD_LAT);
      check("cpu_rd_data", CPU_RDATA, 8'h5A);
      check("cpu_rd_no_dma_valid", dma_vcnt, v_dma);
      tick();
      repeat (3) tick();

      // Alternating reads return in order to the right port
      ret_log.delete();
      issue(1'b0, 1'b0, 8'h01, 8'h00);
      issue(1'b1, 1'b0, 8'h02, 8'h00);
      issue(1'b0, 1'b0, 8'h03, 8'h00);
      repeat (6) tick();
      check("alt_count", ret_log.size(), 3);
      if (ret_log.size() == 3) begin
         check("alt_ret0", ret_log[0], {1'b0, 8'hA1});
         check("alt_ret1", ret_log[1], {1'b1, 8'hA2});
         check("alt_ret2", ret_log[2], {1'b0, 8'hA3});
      end

      // Randomised traffic on a small address window with occasional abandoned requests
      for (int c = 0; c < 600; c++) begin
         @(negedge CLK);
         ca = CPU_REQ && CPU_GNT;
         da = DMA_REQ && DMA_GNT;
         tick();
         if (CPU_REQ && !ca && $urandom_range(0, 15) == 0) CPU_REQ = 0;
         else if (!CPU_REQ || ca) begin
            CPU_REQ   = ($urandom_range(0, 3) != 0);
            CPU_WE    = 1'($urandom_range(0, 1));
            CPU_ADDR  = AW'($urandom_range(0, 15));
            CPU_WDATA = DW'($urandom);
         end
         if (DMA_REQ && !da && $urandom_range(0, 15) == 0) DMA_REQ = 0;
         else if (!DMA_REQ || da) begin
            DMA_REQ   = ($urandom_range(0, 2) == 0);
            DMA_WE    = 1'($urandom_range(0, 1));
            DMA_ADDR  = AW'($urandom_range(0, 15));
            DMA_WDATA = DW'($urandom);
         end
      end
      CPU_REQ = 0; DMA_REQ = 0;
      repeat (8) tick();
      check("random_drained", exp_q.size(), 0);

      // Reset right after a read is accepted discards the read
      issue(1'b0, 1'b0, 8'h02, 8'h00);
      RESET = 1'b1;
      @(negedge CLK);
      check("midrd_rst_outputs", {MEM_ADDR, MEM_DATA, MEM_MW, CPU_VALID, CPU_RDATA}, '0);
      tick();
      tick();
      RESET = 1'b0;
      v_cpu = cpu_vcnt;
      v_dma = dma_vcnt;
      repeat (8) tick();
      check("midrd_no_cpu_valid", cpu_vcnt, v_cpu);
      check("midrd_no_dma_valid", dma_vcnt, v_dma);
      check("final_queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog: actual=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
